// File: rtl/music_note_player.sv
// music_note_player: steps a note ROM once per beat and drives a buzzer with a
// 50% duty square wave at each note's pitch, leaving a short silent gap per beat.
module music_note_player #(
    parameter int CLK_HZ       = 12_000_000,
    parameter int BEAT_CYCLES  = 3_000_000,
    parameter int ARTIC_CYCLES = 300_000,
    parameter int SONG_LEN     = 84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       loop,
    output logic [7:0] rom_addr,
    input  logic [4:0] rom_data,
    output logic [4:0] note,
    output logic       beeper,
    output logic       busy,
    output logic       done
);
    localparam int BW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [BW-1:0] GAP_START = BW'(BEAT_CYCLES - ARTIC_CYCLES);
    localparam logic [7:0] ADDR_LAST = 8'(SONG_LEN - 1);

    // Half-period in clocks for a note code; 0 marks a rest.
    function automatic logic [15:0] hp_calc(input int c);
        longint fc;
        if (c < 1 || c > 21) begin
            hp_calc = 16'd0;
        end else begin
            case ((c - 1) % 7)
                0:       fc = 26163;
                1:       fc = 29366;
                2:       fc = 32963;
                3:       fc = 34923;
                4:       fc = 39200;
                5:       fc = 44000;
                default: fc = 49388;
            endcase
            fc = fc << ((c - 1) / 7);
            hp_calc = 16'((longint'(CLK_HZ) * 50 + fc / 2) / fc);
        end
    endfunction

    logic [15:0] hp_tab [32];
    for (genvar i = 0; i < 32; i++) begin : g_hp
        assign hp_tab[i] = hp_calc(i);
    end

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;
    state_t state, state_nx;
    logic [BW-1:0] beat_cnt;
    logic [15:0] tone_cnt, hp;
    logic tone_q, last_beat, gap;

    assign last_beat = beat_cnt == BEAT_LAST;
    assign gap = beat_cnt >= GAP_START;

    always_comb begin
        state_nx = state;
        busy = state == FETCH || state == PLAY;
        done = state == DONE;
        if (!play)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = FETCH;
                FETCH:   state_nx = PLAY;
                PLAY:    state_nx = !last_beat ? PLAY : (rom_addr != ADDR_LAST || loop) ? FETCH : DONE;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            note     <= '0;
            beeper   <= 1'b0;
            beat_cnt <= '0;
            tone_cnt <= '0;
            hp       <= '0;
            tone_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            beeper <= play && tone_q && !gap && state == PLAY;
            if (state_nx == IDLE) begin
                rom_addr <= '0;
                note     <= '0;
                beat_cnt <= '0;
                tone_cnt <= '0;
                hp       <= '0;
                tone_q   <= 1'b0;
            end else if (state == FETCH) begin
                note     <= rom_data;
                hp       <= hp_tab[rom_data];
                beat_cnt <= '0;
                tone_cnt <= '0;
                tone_q   <= 1'b0;
            end else if (state == PLAY) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (state_nx == FETCH)
                    rom_addr <= rom_addr == ADDR_LAST ? 8'd0 : rom_addr + 8'd1;
                // Rests keep the tone generator parked so the next note starts in phase.
                if (hp == 16'd0) begin
                    tone_cnt <= '0;
                    tone_q   <= 1'b0;
                end else if (tone_cnt == hp - 16'd1) begin
                    tone_cnt <= '0;
                    tone_q   <= ~tone_q;
                end else begin
                    tone_cnt <= tone_cnt + 16'd1;
                end
            end
        end
    end
endmodule
